// File: rtl/noise_mix_pkg.sv
// Shared definitions for the noise_mix_stream slice: FSM encoding, LFSR constants
// and the signed saturation-limit helpers.
package noise_mix_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // 16-bit Fibonacci LFSR, taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'b1011_0100_0000_0000;

  function automatic logic [15:0] lfsr_seed(input int unsigned channel);
    return LFSR_SEED ^ 16'(channel);
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] state_bits);
    return {state_bits[14:0], ^(state_bits & LFSR_TAPS)};
  endfunction

  // Largest / smallest two's-complement value for a given width; callers keep the low bits
  function automatic logic [31:0] sat_max(input int unsigned width);
    return (32'd1 << (width - 1)) - 32'd1;
  endfunction

  function automatic logic [31:0] sat_min(input int unsigned width);
    return ~sat_max(width);
  endfunction

endpackage

// File: rtl/noise_mix_lane.sv
// One channel of the mixer: arithmetic noise shift, widened add, then clamp or wrap
// with a flag whenever the true sum does not fit in WIDTH bits.
module noise_mix_lane
  import noise_mix_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SAT_MODE    = 1,
  parameter int NOISE_SHIFT = 0
) (
  input  logic [WIDTH-1:0] clean,
  input  logic [WIDTH-1:0] noise,
  output logic [WIDTH-1:0] mixed,
  output logic [WIDTH-1:0] noise_shifted,
  output logic             flag
);

  localparam logic [31:0] MAX_FULL = sat_max(WIDTH);
  localparam logic [31:0] MIN_FULL = sat_min(WIDTH);

  logic signed [WIDTH:0] sum;
  logic                  overflow;

  assign noise_shifted = $signed(noise) >>> NOISE_SHIFT;
  assign sum = $signed({clean[WIDTH-1], clean}) + $signed({noise_shifted[WIDTH-1], noise_shifted});
  assign overflow = sum[WIDTH] ^ sum[WIDTH-1];

  // The extra sign bit tells which rail to clamp to when the sum left the range
  always_comb begin
    mixed = sum[WIDTH-1:0];
    flag  = overflow;
    if (SAT_MODE != 0 && overflow) begin
      mixed = sum[WIDTH] ? MIN_FULL[WIDTH-1:0] : MAX_FULL[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/noise_mix_stream.sv
// Joins a clean and a noise stream into aligned mixed/clean/noise outputs over a bounded run.
// Define NOISE_MIX_LFSR_EN to replace the noise input with per-channel internal LFSRs.
module noise_mix_stream
  import noise_mix_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int CHANNELS    = 1,
  parameter int NUM_SAMPLES = 500001,
  parameter int SAT_MODE    = 1,
  parameter int NOISE_SHIFT = 0
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         start,
  input  logic                         clean_valid,
  output logic                         clean_ready,
  input  logic [CHANNELS*WIDTH-1:0]    clean_data,
  input  logic                         noise_valid,
  output logic                         noise_ready,
  input  logic [CHANNELS*WIDTH-1:0]    noise_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CHANNELS*WIDTH-1:0]    out_mixed,
  output logic [CHANNELS*WIDTH-1:0]    out_clean,
  output logic [CHANNELS*WIDTH-1:0]    out_noise,
  output logic [CHANNELS-1:0]          sat_flag,
  output logic [31:0]                  sample_count,
  output logic                         busy,
  output logic                         done
);

  localparam int          BUS_W      = CHANNELS * WIDTH;
  localparam logic [31:0] COUNT_MAX  = 32'(NUM_SAMPLES);
  localparam logic [31:0] LAST_COUNT = 32'(NUM_SAMPLES - 1);

  state_t             state, state_next;
  logic               accept;
  logic               noise_ok;
  logic               start_run;
  logic               last_beat;
  logic [BUS_W-1:0]   noise_src;
  logic [BUS_W-1:0]   lane_mixed;
  logic [BUS_W-1:0]   lane_noise;
  logic [CHANNELS-1:0] lane_flag;

  assign start_run   = start && (state == IDLE || state == DONE);
  assign accept      = (state == RUN) && clean_valid && noise_ok && (!out_valid || out_ready);
  assign last_beat   = accept && (sample_count == LAST_COUNT);
  assign clean_ready = accept;
  assign busy        = (state == RUN) || (state == DRAIN);
  assign done        = (state == DONE);

`ifdef NOISE_MIX_LFSR_EN
  logic unused_noise_in;

  assign unused_noise_in = ^{noise_valid, noise_data};
  assign noise_ok        = 1'b1;
  assign noise_ready     = 1'b0;

  // Each channel owns its generator so channels stay decorrelated by their seeds
  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_lfsr
    logic [15:0] lfsr_q;

    always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
        lfsr_q <= lfsr_seed(ch);
      end else if (start_run) begin
        lfsr_q <= lfsr_seed(ch);
      end else if (accept) begin
        lfsr_q <= lfsr_next(lfsr_q);
      end
    end

    assign noise_src[ch*WIDTH +: WIDTH] = lfsr_q[WIDTH-1:0];
  end
`else
  assign noise_ok    = noise_valid;
  assign noise_ready = accept;
  assign noise_src   = noise_data;
`endif

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_lane
    noise_mix_lane #(
      .WIDTH       (WIDTH),
      .SAT_MODE    (SAT_MODE),
      .NOISE_SHIFT (NOISE_SHIFT)
    ) u_lane (
      .clean         (clean_data[ch*WIDTH +: WIDTH]),
      .noise         (noise_src[ch*WIDTH +: WIDTH]),
      .mixed         (lane_mixed[ch*WIDTH +: WIDTH]),
      .noise_shifted (lane_noise[ch*WIDTH +: WIDTH]),
      .flag          (lane_flag[ch])
    );
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // DRAIN finishes once the register is empty or is being emptied this cycle
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_beat) state_next = DRAIN;
      DRAIN:   if (!out_valid || out_ready) state_next = DONE;
      DONE:    if (start) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      out_valid <= 1'b0;
      out_mixed <= '0;
      out_clean <= '0;
      out_noise <= '0;
      sat_flag  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_mixed <= lane_mixed;
      out_clean <= clean_data;
      out_noise <= lane_noise;
      sat_flag  <= lane_flag;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // The count restarts with every run and sticks at the run length
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sample_count <= '0;
    end else if (start_run) begin
      sample_count <= '0;
    end else if (accept && sample_count != COUNT_MAX) begin
      sample_count <= sample_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_noise_mix_stream.sv
// Directed bench for noise_mix_stream: three parallel instances (saturate, wrap, shifted
// noise) share one stimulus sequence and are checked against hand-computed vectors.
module tb_noise_mix_stream;

  localparam int W  = 8;
  localparam int CH = 2;
  localparam int NS = 4;
  localparam int BW = W * CH;

  logic          Clk = 1'b0;
  logic          Reset = 1'b0;
  logic          start = 1'b0;
  logic          clean_valid = 1'b0;
  logic          noise_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [BW-1:0] clean_data = '0;
  logic [BW-1:0] noise_data = '0;

  logic          a_clean_ready, a_noise_ready, a_out_valid, a_busy, a_done;
  logic [BW-1:0] a_out_mixed, a_out_clean, a_out_noise;
  logic [CH-1:0] a_sat_flag;
  logic [31:0]   a_sample_count;

  logic          b_clean_ready, b_noise_ready, b_out_valid, b_busy, b_done;
  logic [BW-1:0] b_out_mixed, b_out_clean, b_out_noise;
  logic [CH-1:0] b_sat_flag;
  logic [31:0]   b_sample_count;

  logic          c_clean_ready, c_noise_ready, c_out_valid, c_busy, c_done;
  logic [BW-1:0] c_out_mixed, c_out_clean, c_out_noise;
  logic [CH-1:0] c_sat_flag;
  logic [31:0]   c_sample_count;

  int n_compared   = 0;
  int n_mismatched = 0;

  always #5 Clk = ~Clk;

  noise_mix_stream #(.WIDTH(W), .CHANNELS(CH), .NUM_SAMPLES(NS), .SAT_MODE(1), .NOISE_SHIFT(0)) dut_sat (
    .Clk(Clk), .Reset(Reset), .start(start),
    .clean_valid(clean_valid), .clean_ready(a_clean_ready), .clean_data(clean_data),
    .noise_valid(noise_valid), .noise_ready(a_noise_ready), .noise_data(noise_data),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .out_mixed(a_out_mixed), .out_clean(a_out_clean), .out_noise(a_out_noise),
    .sat_flag(a_sat_flag), .sample_count(a_sample_count), .busy(a_busy), .done(a_done)
  );

  noise_mix_stream #(.WIDTH(W), .CHANNELS(CH), .NUM_SAMPLES(NS), .SAT_MODE(0), .NOISE_SHIFT(0)) dut_wrap (
    .Clk(Clk), .Reset(Reset), .start(start),
    .clean_valid(clean_valid), .clean_ready(b_clean_ready), .clean_data(clean_data),
    .noise_valid(noise_valid), .noise_ready(b_noise_ready), .noise_data(noise_data),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .out_mixed(b_out_mixed), .out_clean(b_out_clean), .out_noise(b_out_noise),
    .sat_flag(b_sat_flag), .sample_count(b_sample_count), .busy(b_busy), .done(b_done)
  );

  noise_mix_stream #(.WIDTH(W), .CHANNELS(CH), .NUM_SAMPLES(NS), .SAT_MODE(1), .NOISE_SHIFT(2)) dut_shift (
    .Clk(Clk), .Reset(Reset), .start(start),
    .clean_valid(clean_valid), .clean_ready(c_clean_ready), .clean_data(clean_data),
    .noise_valid(noise_valid), .noise_ready(c_noise_ready), .noise_data(noise_data),
    .out_valid(c_out_valid), .out_ready(out_ready),
    .out_mixed(c_out_mixed), .out_clean(c_out_clean), .out_noise(c_out_noise),
    .sat_flag(c_sat_flag), .sample_count(c_sample_count), .busy(c_busy), .done(c_done)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic cv, input logic nv, input logic [BW-1:0] cd,
                               input logic [BW-1:0] nd, input logic ordy);
    clean_valid = cv;
    noise_valid = nv;
    clean_data  = cd;
    noise_data  = nd;
    out_ready   = ordy;
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    // Reset values
    #1 Reset = 1'b1;
    tick;
    checkOutput("rst_valid", a_out_valid, 0);
    checkOutput("rst_mixed", a_out_mixed, 0);
    checkOutput("rst_count", a_sample_count, 0);
    checkOutput("rst_done", a_done, 0);
    checkOutput("rst_busy", a_busy, 0);
    checkOutput("rst_ready", a_clean_ready, 0);
    #2 Reset = 1'b0;
    tick;

    start = 1'b1;
    tick;
    start = 1'b0;
    checkOutput("run_busy", a_busy, 1);
    checkOutput("run_count", a_sample_count, 0);

    // Beat 1: ch0 positive clip / wrap, ch1 cancels to zero
    applyStimulus(1, 1, 16'h1070, 16'hF020, 1);
    #1;
    checkOutput("b1_clean_ready", a_clean_ready, 1);
    checkOutput("b1_noise_ready", a_noise_ready, 1);
    tick;
    checkOutput("b1_sat_mixed", a_out_mixed, 16'h007F);
    checkOutput("b1_sat_flag", a_sat_flag, 2'b01);
    checkOutput("b1_sat_clean", a_out_clean, 16'h1070);
    checkOutput("b1_sat_noise", a_out_noise, 16'hF020);
    checkOutput("b1_valid", a_out_valid, 1);
    checkOutput("b1_wrap_mixed", b_out_mixed, 16'h0090);
    checkOutput("b1_wrap_flag", b_sat_flag, 2'b01);
    checkOutput("b1_shift_mixed", c_out_mixed, 16'h0C78);
    checkOutput("b1_shift_noise", c_out_noise, 16'hFC08);
    checkOutput("b1_shift_flag", c_sat_flag, 2'b00);
    checkOutput("b1_count", a_sample_count, 1);

    // Join: clean alone must never be consumed
    applyStimulus(1, 0, 16'h0005, 16'h0080, 1);
    repeat (5) begin
      #1;
      checkOutput("join_clean_ready", a_clean_ready, 0);
      tick;
    end
    checkOutput("join_valid", a_out_valid, 0);
    checkOutput("join_count", a_sample_count, 1);

    applyStimulus(1, 1, 16'h0005, 16'h0080, 1);
    #1;
    checkOutput("b2_ready", a_clean_ready, 1);
    tick;
    applyStimulus(0, 0, 16'h0005, 16'h0080, 1);
    checkOutput("b2_count", a_sample_count, 2);
    checkOutput("b2_sat_mixed", a_out_mixed, 16'h0085);
    checkOutput("b2_sat_noise", a_out_noise, 16'h0080);
    checkOutput("b2_wrap_mixed", b_out_mixed, 16'h0085);
    checkOutput("b2_shift_mixed", c_out_mixed, 16'h00E5);
    checkOutput("b2_shift_noise", c_out_noise, 16'h00E0);
    checkOutput("b2_shift_flag", c_sat_flag, 2'b00);
    tick;
    checkOutput("b2_single_count", a_sample_count, 2);
    checkOutput("b2_drained", a_out_valid, 0);

    // Beat 3 with downstream stalled: negative and positive clipping
    applyStimulus(1, 1, 16'h807F, 16'h8001, 0);
    #1;
    checkOutput("b3_ready", a_clean_ready, 1);
    tick;
    checkOutput("b3_sat_mixed", a_out_mixed, 16'h807F);
    checkOutput("b3_sat_flag", a_sat_flag, 2'b11);
    checkOutput("b3_wrap_mixed", b_out_mixed, 16'h0080);
    checkOutput("b3_wrap_flag", b_sat_flag, 2'b11);
    checkOutput("b3_shift_mixed", c_out_mixed, 16'h807F);
    checkOutput("b3_shift_flag", c_sat_flag, 2'b10);
    checkOutput("b3_shift_noise", c_out_noise, 16'hE000);
    checkOutput("b3_count", a_sample_count, 3);

    applyStimulus(1, 1, 16'h0102, 16'h0304, 0);
    repeat (3) begin
      #1;
      checkOutput("stall_ready", a_clean_ready, 0);
      tick;
      checkOutput("stall_hold", a_out_mixed, 16'h807F);
    end
    checkOutput("stall_valid", a_out_valid, 1);
    checkOutput("stall_count", a_sample_count, 3);

    // Release: final accept and output take in the same cycle
    out_ready = 1'b1;
    #1;
    checkOutput("b4_ready", a_clean_ready, 1);
    tick;
    checkOutput("b4_sat_mixed", a_out_mixed, 16'h0406);
    checkOutput("b4_shift_mixed", c_out_mixed, 16'h0103);
    checkOutput("b4_count", a_sample_count, 4);
    checkOutput("drain_busy", a_busy, 1);
    checkOutput("drain_done", a_done, 0);
    checkOutput("drain_valid", a_out_valid, 1);
    #1;
    checkOutput("drain_ready", a_clean_ready, 0);
    tick;
    applyStimulus(0, 0, 16'h0000, 16'h0000, 1);
    checkOutput("done_done", a_done, 1);
    checkOutput("done_busy", a_busy, 0);
    checkOutput("done_valid", a_out_valid, 0);
    checkOutput("done_count", a_sample_count, 4);
    checkOutput("done_wrap_done", b_done, 1);
    tick;
    checkOutput("done_held", a_done, 1);

    // Restart, then reset mid-run after two beats
    start = 1'b1;
    tick;
    start = 1'b0;
    checkOutput("rerun_count", a_sample_count, 0);
    checkOutput("rerun_done", a_done, 0);
    applyStimulus(1, 1, 16'h0001, 16'h0001, 1);
    tick;
    applyStimulus(1, 1, 16'h0002, 16'h0002, 1);
    tick;
    checkOutput("mid_count", a_sample_count, 2);
    checkOutput("mid_mixed", a_out_mixed, 16'h0004);
    Reset = 1'b1;
    #1;
    checkOutput("mrst_valid", a_out_valid, 0);
    checkOutput("mrst_mixed", a_out_mixed, 0);
    checkOutput("mrst_clean", a_out_clean, 0);
    checkOutput("mrst_count", a_sample_count, 0);
    checkOutput("mrst_busy", a_busy, 0);
    checkOutput("mrst_done", a_done, 0);
    checkOutput("mrst_ready", a_clean_ready, 0);
    #2 Reset = 1'b0;
    applyStimulus(0, 0, 16'h0000, 16'h0000, 1);
    tick;

    // Full back-to-back run of four beats at one per clock
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 1; k <= NS; k++) begin
      applyStimulus(1, 1, 16'(k), 16'(k), 1);
      tick;
      checkOutput("b2b_mixed", a_out_mixed, 32'(2 * k));
      checkOutput("b2b_count", a_sample_count, 32'(k));
    end
    applyStimulus(0, 0, 16'h0000, 16'h0000, 1);
    checkOutput("b2b_last_valid", a_out_valid, 1);
    checkOutput("b2b_drain_busy", a_busy, 1);
    tick;
    checkOutput("b2b_done", a_done, 1);
    checkOutput("b2b_final_count", a_sample_count, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/noise_mix_stream.md
Name: noise_mix_stream

Overview:
- Synthesizable, parametrised successor to the bench-side "clean + noise" sample mixer that drives the LMS filter / AC97 audio path.
- Joins a clean-sample stream and a noise stream and produces three aligned outputs per sample: the mixed sample, the clean reference and the noise.
- Adds per-channel vectors, selectable saturate/wrap arithmetic, noise attenuation, a ready/valid handshake and a bounded run length with done reporting.
- Sits between sample sources (ROM/stream or LFSR) and the LMS filter input/desired ports.

Parameters:
- WIDTH, 8, bits per sample; samples are two's-complement signed.
- CHANNELS, 1, number of independent channels packed LSB-first (channel 0 in the low WIDTH bits).
- NUM_SAMPLES, 500001, sample vectors per run; must be ≥1.
- SAT_MODE, 1: 1 = saturating add, 0 = modulo-2^WIDTH wrap.
- NOISE_SHIFT, 0, arithmetic right shift applied to noise before the add; range 0..WIDTH-1.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE.
- clean_valid  in  1  clean_data is valid.
- clean_ready  out  1  clean beat accepted this cycle.
- clean_data  in  CHANNELS*WIDTH  clean samples.
- noise_valid  in  1  noise_data is valid.
- noise_ready  out  1  noise beat accepted this cycle.
- noise_data  in  CHANNELS*WIDTH  noise samples.
- out_valid  out  1  output register holds a sample.
- out_ready  in  1  downstream accepts.
- out_mixed  out  CHANNELS*WIDTH  clean + (noise >>> NOISE_SHIFT).
- out_clean  out  CHANNELS*WIDTH  clean sample, aligned to out_mixed.
- out_noise  out  CHANNELS*WIDTH  shifted noise, aligned to out_mixed.
- sat_flag  out  CHANNELS  per channel, 1 if the current out_mixed clipped (SAT_MODE=1) or wrapped (SAT_MODE=0).
- sample_count  out  32  number of beats accepted this run.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  high in DONE.

Behaviour:
- Reset values: all outputs 0; state IDLE; output register empty.
- FSM states:
  - IDLE: start -> RUN; sample_count is cleared to 0 on entry to RUN.
  - RUN: accepts beats. When the NUM_SAMPLES-th beat is accepted -> DRAIN.
  - DRAIN: waits for the last output to be taken (out_valid && out_ready) -> DONE. If out_valid is already 0, it transitions in the next cycle.
  - DONE: done=1 and held. start -> RUN with the count cleared.
  - start is ignored in RUN and DRAIN.
- Join rule:
  - Define accept = (state==RUN) && clean_valid && noise_valid && (!out_valid || out_ready).
  - clean_ready = noise_ready = accept.
  - A beat is never consumed from one stream without the other.
  - ready may depend on valid; valid must never depend on ready.
- Latency: 1 cycle. The accepted beat appears on the out_* registers in the next cycle with out_valid=1.
- Back-to-back acceptance is allowed while out_ready=1, giving 1 sample/clk throughput.
- out_* is held stable while out_valid && !out_ready.
- out_valid clears on (out_valid && out_ready && !accept).
- Arithmetic, per channel:
  - n = noise >>> NOISE_SHIFT (sign-preserving).
  - Sum computed at WIDTH+1 bits.
  - SAT_MODE=1: clamp to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; sat_flag=1 when clamped.
  - SAT_MODE=0: low WIDTH bits; sat_flag=1 when overflow occurred.
- sample_count increments on every accept. It saturates at NUM_SAMPLES and never wraps.
- Simultaneous events: a final accept and out_ready in the same cycle are both honoured. DRAIN then sees the new register contents.
- Reset asserted mid-run: immediate return to IDLE, output register emptied, in-flight beat discarded, count cleared.

Optional Feature:
- Macro NOISE_MIX_LFSR_EN.
- Defined:
  - noise is taken from an internal 16-bit Fibonacci LFSR per channel (taps 16,14,13,11; seed 16'hACE1 XOR channel index; never all-zero). The low WIDTH bits form the noise sample.
  - The LFSR advances on each accept.
  - noise_valid is ignored (treated as 1); noise_ready is driven 0.
  - The LFSR is reseeded on Reset and on start.
- Not defined: the noise ports behave as above and no LFSR logic is synthesised.

Decomposition:
- Package noise_mix_pkg holds:
  - FSM state encoding: IDLE=2'd0, RUN=2'd1, DRAIN=2'd2, DONE=2'd3.
  - LFSR seed/tap constants.
  - The saturation limit helper: max/min for a given WIDTH.
- One sub-module, noise_mix_lane: combinational shift + add + saturate/wrap + flag for one channel. It is instantiated CHANNELS times by generate.
- FSM, join logic and output register stay in the top.

Test Plan:
- WIDTH=8, SAT_MODE=1, clean=8'h70, noise=8'h20, out_ready=1 -> next cycle out_mixed=8'h7F, sat_flag=1, out_clean=8'h70, out_noise=8'h20.
- SAT_MODE=0, clean=8'h70, noise=8'h20 -> out_mixed=8'h90, sat_flag=1. With clean=8'h10, noise=8'hF0 -> out_mixed=8'h00, sat_flag=0.
- NOISE_SHIFT=2, noise=8'h80 -> out_noise=8'hE0. With clean=8'h05 -> out_mixed=8'hE5.
- clean_valid=1, noise_valid=0 for 5 cycles -> clean_ready stays 0, no output; then noise_valid=1 -> exactly one beat accepted.
- NUM_SAMPLES=4, out_ready held 0 after the first output -> accepts stall with out_* stable; releasing out_ready -> 4 outputs in order, busy falls, done=1, sample_count=4.
- Reset pulsed after 2 of 4 beats -> all outputs 0, state IDLE. A new start runs the full 4 beats, and (with NOISE_MIX_LFSR_EN) the noise sequence restarts from seed 16'hACE1.
